// File: rtl/queue_pkg.sv
// Shared types and sizing helpers for the queue sensor front end.
package queue_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConfirmHigh,
        StHigh,
        StConfirmLow
    } sensor_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int unsigned STUCK_CYCLES_DEFAULT    = 1000;

    // Bits needed to hold every value from 0 up to and including max_value.
    function automatic int unsigned cnt_width(input int unsigned max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, debounce FSM, single entry pulse and
// saturating stuck detector.
module sensor_debounce
    import queue_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sensor_i,
    output logic pulse_o,
    output logic stuck_o
);

    localparam int unsigned DCW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned SCW = cnt_width(STUCK_CYCLES);
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCW-1:0] STUCK_MAX = SCW'(STUCK_CYCLES);

    logic          sync_meta_q, sync_q;
    sensor_state_e state_q;
    logic [DCW-1:0] deb_cnt_q;
    logic [SCW-1:0] stuck_cnt_q;
    logic          fresh_q, pulse_q, stuck_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            sync_meta_q <= sensor_i;
            sync_q      <= sync_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            deb_cnt_q   <= '0;
            stuck_cnt_q <= '0;
            fresh_q     <= 1'b0;
            pulse_q     <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            // fresh_q marks the first cycle in StHigh; the pulse follows it by one edge.
            pulse_q <= fresh_q;
            fresh_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sync_q) begin
                        state_q   <= StConfirmHigh;
                        deb_cnt_q <= DCW'(1);
                    end
                end
                StConfirmHigh: begin
                    if (!sync_q) begin
                        state_q <= StIdle;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q <= StHigh;
                        fresh_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DCW'(1);
                    end
                end
                StHigh: begin
                    if (!sync_q) begin
                        state_q   <= StConfirmLow;
                        deb_cnt_q <= DCW'(1);
                    end
                end
                StConfirmLow: begin
                    if (sync_q) begin
                        state_q <= StHigh;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q <= StIdle;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DCW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (state_q == StHigh || state_q == StConfirmLow) begin
                if (stuck_cnt_q != STUCK_MAX) begin
                    stuck_cnt_q <= stuck_cnt_q + SCW'(1);
                end
                stuck_q <= (stuck_cnt_q == STUCK_MAX);
            end else begin
                stuck_cnt_q <= '0;
                stuck_q     <= 1'b0;
            end
        end
    end

    assign pulse_o = pulse_q;
    assign stuck_o = stuck_q;

endmodule

// File: rtl/queue_sensor_frontend.sv
// Entry/exit sensor front end feeding a queue counter. Define SIMUL_CANCEL_EN to
// suppress Up and Down when both fall in the same cycle.
module queue_sensor_frontend
    import queue_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic reset,
    input  logic Entry_Sensor,
    input  logic Exit_Sensor,
    output logic Up,
    output logic Down,
    output logic Stuck_Flag
);

    logic entry_pulse, exit_pulse;
    logic entry_stuck, exit_stuck;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_entry (
        .clk_i    (CLK),
        .rst_i    (reset),
        .sensor_i (Entry_Sensor),
        .pulse_o  (entry_pulse),
        .stuck_o  (entry_stuck)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_exit (
        .clk_i    (CLK),
        .rst_i    (reset),
        .sensor_i (Exit_Sensor),
        .pulse_o  (exit_pulse),
        .stuck_o  (exit_stuck)
    );

`ifdef SIMUL_CANCEL_EN
    // Simultaneous entry and exit leave the queue length unchanged.
    logic both_pulse;
    assign both_pulse = entry_pulse & exit_pulse;
    assign Up         = entry_pulse & ~both_pulse;
    assign Down       = exit_pulse & ~both_pulse;
`else
    assign Up   = entry_pulse;
    assign Down = exit_pulse;
`endif

    assign Stuck_Flag = entry_stuck | exit_stuck;

endmodule

// File: doc/queue_sensor_frontend.md
QUEUE_SENSOR_FRONTEND -- requirements
Module: queue_sensor_frontend

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples needed to accept a level change (legal 2..255).
REQ-002 SHALL have parameter STUCK_CYCLES, default 1000, cycles a confirmed-high sensor may stay high before being flagged stuck (must exceed DEBOUNCE_CYCLES).
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Entry_Sensor  input  1  raw, asynchronous, active-high sensor at queue entry.
REQ-006 Exit_Sensor  input  1  raw, asynchronous, active-high sensor at service exit.
REQ-007 Up  output  1  one-cycle pulse per accepted entry event, consumed by the queue counter.
REQ-008 Down  output  1  one-cycle pulse per accepted exit event, consumed by the queue counter.
REQ-009 Stuck_Flag  output  1  high while either sensor is confirmed stuck.

Function
REQ-010 Each sensor SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each channel SHALL run an FSM: IDLE, CONFIRM_HIGH, HIGH, CONFIRM_LOW.
REQ-012 IDLE->CONFIRM_HIGH on a synchronized 1; the debounce counter loads 1.
REQ-013 CONFIRM_HIGH: a synchronized 0 returns to IDLE with no pulse; reaching DEBOUNCE_CYCLES consecutive 1s enters HIGH.
REQ-014 Entry into HIGH SHALL register exactly one pulse, one cycle wide, on that channel (Up for entry, Down for exit).
REQ-015 HIGH->CONFIRM_LOW on a synchronized 0; CONFIRM_LOW returns to HIGH on a 1 and to IDLE after DEBOUNCE_CYCLES consecutive 0s; no pulse on release.
REQ-016 Latency: a clean raw rise stable from edge N SHALL produce the pulse at edge N+DEBOUNCE_CYCLES+2.
REQ-017 Pulses SHALL be registered outputs; at most one pulse per channel per press, regardless of hold time.
REQ-018 Stuck counter SHALL count cycles in HIGH/CONFIRM_LOW and saturate at STUCK_CYCLES; Stuck_Flag asserts the cycle it saturates and clears the cycle the channel returns to IDLE.
REQ-019 A stuck channel SHALL emit no further pulses until it has passed through IDLE.
REQ-020 Counter widths SHALL be sized by clog2 of their parameters; no wrap-around is permitted (saturate).

Reset
REQ-021 reset SHALL asynchronously force both FSMs to IDLE, clear synchronizers and counters, and set Up=0, Down=0, Stuck_Flag=0.
REQ-022 Reset asserted mid-debounce or mid-HIGH SHALL discard the event; after release a still-high sensor SHALL be re-qualified from IDLE and pulse once.

Configuration
REQ-023 Macro SIMUL_CANCEL_EN: when defined, Up and Down due in the same cycle SHALL both be suppressed (net count unchanged); when undefined, both SHALL be emitted in the same cycle.

Structure
REQ-024 The FSM state enum, the DEBOUNCE_CYCLES/STUCK_CYCLES defaults and the counter-width function SHALL live in the shared package queue_pkg.
REQ-025 One sub-module, sensor_debounce (synchronizer + FSM + pulse + stuck counter), SHALL be instantiated twice; the top holds only the simultaneity logic and the Stuck_Flag OR.

Verification
REQ-026 Entry_Sensor rises and holds 20 cycles -> one Up pulse at cycle 6 (default), Down stays 0.
REQ-027 Entry_Sensor glitches high for 3 cycles -> no Up pulse, FSM back in IDLE.
REQ-028 Exit_Sensor bounces 1-0-1 every cycle for 6 cycles then holds high -> exactly one Down pulse, 6 cycles after the final stable rise.
REQ-029 Both sensors rise in the same cycle -> with SIMUL_CANCEL_EN, no pulses; without it, Up=Down=1 in the same cycle.
REQ-030 Entry_Sensor held 1200 cycles -> Up once, Stuck_Flag=1 from cycle 1000+6 until 4+2 cycles after release; no further Up.
REQ-031 reset pulsed during CONFIRM_HIGH with the sensor still high -> outputs 0 during reset, then one Up 6 cycles after reset release.
